// File: rtl/pipe_add_sub.sv
// ---------------------------------------------------------------------------
// pipe_add_sub
//   Pipelined two's-complement adder/subtractor with a per-operation add/sub
//   select. The carry chain is cut into CHUNK-bit slices, one slice per
//   register stage. Operand slices above the current stage ride along in skew
//   registers; finished result slices ride along until the top slice lands,
//   so the whole word leaves together.
//
// Ports
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (deassertion synchronised outside)
//   i_ce     clock enable; 0 freezes every register, outputs included
//   i_valid  operand pair valid this cycle
//   i_sub    0: a+b, 1: a-b (travels with its operands)
//   i_a/i_b  operands, WIDTH bits
//   o_valid  result valid (final-stage valid bit)
//   o_res    result modulo 2^WIDTH, held between valid results
//   o_c      add: carry-out, sub: borrow (unsigned a < b)
//   o_ovf    signed overflow
//
// Handshake: there is no ready. A pair is accepted on every rising edge with
//   i_ce=1 and i_valid=1; its result is presented with o_valid=1 after
//   STAGES enabled edges. Edges with i_ce=0 do not advance anything.
// ---------------------------------------------------------------------------
module pipe_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ce,
  input  logic             i_valid,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_res,
  output logic             o_c,
  output logic             o_ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Per-stage inputs: index 0 comes straight from the ports, index k from the
  // register bank written by stage k-1.
  logic [WIDTH-1:0] w_a_in    [STAGES];
  logic [WIDTH-1:0] w_bx_in   [STAGES];  // b' = b, or ~b when subtracting
  logic [WIDTH-1:0] w_sum_in  [STAGES];
  logic [WIDTH-1:0] w_sum_out [STAGES];
  logic             w_cin     [STAGES];
  logic             w_vld_in  [STAGES];
  logic             w_sub_in  [STAGES];
  logic [CHUNK:0]   w_slice   [STAGES];  // {carry, slice sum}

  // a - b = a + ~b + 1: invert once at the input, feed i_sub as carry-in.
  assign w_a_in[0]   = i_a;
  assign w_bx_in[0]  = i_b ^ {WIDTH{i_sub}};
  assign w_sum_in[0] = '0;
  assign w_cin[0]    = i_sub;
  assign w_vld_in[0] = i_valid;
  assign w_sub_in[0] = i_sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

    assign w_slice[k] = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                      + {1'b0, w_bx_in[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, w_cin[k]};

    // Merge this stage's slice into the partially built result word.
    assign w_sum_out[k] = (w_sum_in[k] & ~MASK)
                        | (WIDTH'(w_slice[k][CHUNK-1:0]) << (k * CHUNK));
  end

  // Inter-stage registers exist only when there is more than one slice.
  // They load on every enabled edge; validity is carried by r_vld alone.
  if (STAGES > 1) begin : g_pipe
    logic [WIDTH-1:0] r_a   [STAGES-1];
    logic [WIDTH-1:0] r_bx  [STAGES-1];
    logic [WIDTH-1:0] r_sum [STAGES-1];
    logic             r_cy  [STAGES-1];
    logic             r_vld [STAGES-1];
    logic             r_sub [STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int k = 0; k < STAGES - 1; k++) begin
          r_a[k]   <= '0;
          r_bx[k]  <= '0;
          r_sum[k] <= '0;
          r_cy[k]  <= 1'b0;
          r_vld[k] <= 1'b0;
          r_sub[k] <= 1'b0;
        end
      end else if (i_ce) begin
        for (int k = 0; k < STAGES - 1; k++) begin
          r_a[k]   <= w_a_in[k];
          r_bx[k]  <= w_bx_in[k];
          r_sum[k] <= w_sum_out[k];
          r_cy[k]  <= w_slice[k][CHUNK];
          r_vld[k] <= w_vld_in[k];
          r_sub[k] <= w_sub_in[k];
        end
      end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_link
      assign w_a_in[k]   = r_a[k-1];
      assign w_bx_in[k]  = r_bx[k-1];
      assign w_sum_in[k] = r_sum[k-1];
      assign w_cin[k]    = r_cy[k-1];
      assign w_vld_in[k] = r_vld[k-1];
      assign w_sub_in[k] = r_sub[k-1];
    end
  end

  // Final stage: the top slice completes here and the flags are formed from
  // the operand MSBs that travelled with it.
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_ovf;

  assign w_res = w_sum_out[LAST];
  assign w_c   = w_slice[LAST][CHUNK] ^ w_sub_in[LAST];  // borrow = ~cout
  assign w_ovf = (w_a_in[LAST][WIDTH-1] == w_bx_in[LAST][WIDTH-1])
              && (w_res[WIDTH-1] != w_a_in[LAST][WIDTH-1]);

  logic             r_valid;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic             r_ovf;

  // Result registers only take valid data, so bubbles leave the last result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (i_ce) begin
      r_valid <= w_vld_in[LAST];
      if (w_vld_in[LAST]) begin
        r_res <= w_res;
        r_c   <= w_c;
        r_ovf <= w_ovf;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_res   = r_res;
  assign o_c     = r_c;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_pipe_add_sub.sv
// ---------------------------------------------------------------------------
// tb_pipe_add_sub
//   Four pipe_add_sub instances share one stimulus stream:
//     d0: WIDTH=8,  CHUNK=4  (2 stages)  -- sees the low byte of a/b
//     d1: WIDTH=32, CHUNK=1  (32 stages)
//     d2: WIDTH=32, CHUNK=8  (4 stages)
//     d3: WIDTH=32, CHUNK=32 (1 stage)
//   The driver pushes the arithmetic expectation plus the enabled-edge count
//   at which it is due; the monitor pops on each enabled edge.
// ---------------------------------------------------------------------------
module tb_pipe_add_sub;

  localparam int ND = 4;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        ovf;
    int          due;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce = 1'b1;
  logic        valid = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;

  always #5 clk = ~clk;

  int ecount = 0;      // enabled edges seen since time 0
  bit en_edge = 1'b0;  // was the most recent rising edge enabled

  always @(posedge clk) begin
    en_edge = rst_n && ce;
    if (en_edge) ecount++;
  end

  // ---------------- DUTs ----------------
  logic        mo_valid [ND];
  logic [31:0] mo_res   [ND];
  logic        mo_c     [ND];
  logic        mo_ovf   [ND];
  logic [7:0]  res8;
  logic [31:0] res_d1, res_d2, res_d3;

  pipe_add_sub #(.WIDTH(8), .CHUNK(4)) u_d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_valid(valid), .i_sub(sub),
    .i_a(in_a[7:0]), .i_b(in_b[7:0]),
    .o_valid(mo_valid[0]), .o_res(res8), .o_c(mo_c[0]), .o_ovf(mo_ovf[0]));

  pipe_add_sub #(.WIDTH(32), .CHUNK(1)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_valid(valid), .i_sub(sub),
    .i_a(in_a), .i_b(in_b),
    .o_valid(mo_valid[1]), .o_res(res_d1), .o_c(mo_c[1]), .o_ovf(mo_ovf[1]));

  pipe_add_sub #(.WIDTH(32), .CHUNK(8)) u_d2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_valid(valid), .i_sub(sub),
    .i_a(in_a), .i_b(in_b),
    .o_valid(mo_valid[2]), .o_res(res_d2), .o_c(mo_c[2]), .o_ovf(mo_ovf[2]));

  pipe_add_sub #(.WIDTH(32), .CHUNK(32)) u_d3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_valid(valid), .i_sub(sub),
    .i_a(in_a), .i_b(in_b),
    .o_valid(mo_valid[3]), .o_res(res_d3), .o_c(mo_c[3]), .o_ovf(mo_ovf[3]));

  assign mo_res[0] = {24'd0, res8};
  assign mo_res[1] = res_d1;
  assign mo_res[2] = res_d2;
  assign mo_res[3] = res_d3;

  function automatic int dut_w(input int d);
    return (d == 0) ? 8 : 32;
  endfunction

  function automatic int dut_s(input int d);
    case (d)
      0:       return 2;
      1:       return 32;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Plain integer arithmetic on the mathematical values of the operands.
  function automatic exp_t model(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input logic s);
    exp_t   e;
    longint m, ua, ub, sa, sb, ur, sr;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = (ua > (m >> 1)) ? ua - (m + 1) : ua;
    sb = (ub > (m >> 1)) ? ub - (m + 1) : ub;
    ur = s ? ua - ub : ua + ub;
    sr = s ? sa - sb : sa + sb;
    e.res = 32'(ur & m);
    e.c   = s ? (ua < ub) : (ur > m);
    e.ovf = (sr > (m >> 1)) || (sr < -((m >> 1) + 1));
    e.due = 0;
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t exp_q2[$];
  exp_t exp_q3[$];

  function automatic int q_size(input int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      2:       return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  function automatic exp_t q_front(input int d);
    case (d)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      2:       return exp_q2[0];
      default: return exp_q3[0];
    endcase
  endfunction

  function automatic void q_pop(input int d);
    case (d)
      0:       void'(exp_q0.pop_front());
      1:       void'(exp_q1.pop_front());
      2:       void'(exp_q2.pop_front());
      default: void'(exp_q3.pop_front());
    endcase
  endfunction

  function automatic void q_push(input int d, input exp_t e);
    case (d)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      2:       exp_q2.push_back(e);
      default: exp_q3.push_back(e);
    endcase
  endfunction

  function automatic void q_clear();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    exp_q3.delete();
  endfunction

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s d%0d @%0t: got %h expected %h", name, d, $time, act, exp);
  endtask

  // ---------------- monitor ----------------
  logic        last_v   [ND];
  logic [31:0] last_res [ND];
  logic        last_c   [ND];
  logic        last_ovf [ND];
  exp_t        mon_e;
  logic        mon_exp_v;

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        last_v[d]   = 1'b0;
        last_res[d] = '0;
        last_c[d]   = 1'b0;
        last_ovf[d] = 1'b0;
      end else if (en_edge) begin
        mon_exp_v = 1'b0;
        if (q_size(d) > 0) begin
          mon_e = q_front(d);
          mon_exp_v = (mon_e.due == ecount);
        end
        check("valid", d, 32'(mo_valid[d]), 32'(mon_exp_v));
        if (mon_exp_v) begin
          q_pop(d);
          if (mo_valid[d]) begin
            check("res", d, mo_res[d], mon_e.res);
            check("carry", d, 32'(mo_c[d]), 32'(mon_e.c));
            check("ovf", d, 32'(mo_ovf[d]), 32'(mon_e.ovf));
          end
        end else if (!mo_valid[d]) begin
          check("hold_res", d, mo_res[d], last_res[d]);
          check("hold_c", d, 32'(mo_c[d]), 32'(last_c[d]));
          check("hold_ovf", d, 32'(mo_ovf[d]), 32'(last_ovf[d]));
        end
        last_v[d]   = mo_valid[d];
        last_res[d] = mo_res[d];
        last_c[d]   = mo_c[d];
        last_ovf[d] = mo_ovf[d];
      end else begin
        // Stalled edge: everything must be frozen.
        check("stall_valid", d, 32'(mo_valid[d]), 32'(last_v[d]));
        check("stall_res", d, mo_res[d], last_res[d]);
        check("stall_c", d, 32'(mo_c[d]), 32'(last_c[d]));
        check("stall_ovf", d, 32'(mo_ovf[d]), 32'(last_ovf[d]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic ce_v);
    exp_t e;
    @(negedge clk);
    #1;
    ce    = ce_v;
    valid = v;
    sub   = s;
    in_a  = a;
    in_b  = b;
    if (v && ce_v && rst_n) begin
      for (int d = 0; d < ND; d++) begin
        e     = model(dut_w(d), a, b, s);
        e.due = ecount + dut_s(d);
        q_push(d, e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  // Asserts reset in the middle of the current low clock phase.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check("rst_valid", d, 32'(mo_valid[d]), 32'd0);
      check("rst_res", d, mo_res[d], 32'd0);
      check("rst_c", d, 32'(mo_c[d]), 32'd0);
      check("rst_ovf", d, 32'(mo_ovf[d]), 32'd0);
    end
    q_clear();
    valid = 1'b0;
    ce    = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_007F;
      5:       return 32'h0000_0080;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    async_reset();

    // Signed-overflow boundary, then unsigned carry-out.
    drive(1'b1, 1'b0, 32'h7F, 32'h01, 1'b1);
    drive(1'b1, 1'b0, 32'hFF, 32'h01, 1'b1);
    idle(3);

    // Borrow, then signed underflow.
    drive(1'b1, 1'b1, 32'h00, 32'h01, 1'b1);
    drive(1'b1, 1'b1, 32'h80, 32'h01, 1'b1);
    idle(3);

    // Mode flips every cycle with no bubbles.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'(i % 2), 32'h35, 32'h1C, 1'b1);
    // Carry crossing the slice boundary.
    drive(1'b1, 1'b0, 32'h0F, 32'h01, 1'b1);
    idle(3);

    // valid, bubble, valid.
    drive(1'b1, 1'b0, 32'h12, 32'h34, 1'b1);
    drive(1'b0, 1'b0, 32'hAA, 32'h55, 1'b1);
    drive(1'b1, 1'b1, 32'h40, 32'h41, 1'b1);
    idle(3);

    // One op in flight, then a 3-cycle stall; inputs during the stall
    // carry garbage with valid high and must be ignored.
    drive(1'b1, 1'b0, 32'h21, 32'h43, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, $urandom(), $urandom(), 1'b0);
    idle(4);

    // Reset with operations in flight: none of them may ever appear.
    drive(1'b1, 1'b0, 32'h11, 32'h22, 1'b1);
    drive(1'b1, 1'b1, 32'h33, 32'h44, 1'b1);
    async_reset();
    idle(3);

    // Randomised regression with bubbles and stalls.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
            rnd_val(), rnd_val(), 1'($urandom_range(0, 7) != 0));
    end

    // Drain the deepest pipeline.
    idle(40);

    for (int d = 0; d < ND; d++) check("drained", d, 32'(q_size(d)), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_add_sub.md
# pipe_add_sub

Pipelined, parametrised two's-complement adder/subtractor with a run-time add/sub select per operand pair. The carry chain is split into CHUNK-bit slices, one slice per register stage, so wide operands close timing at full clock rate. It accepts one operation per enabled cycle and returns sum or difference, carry/borrow and signed overflow after a fixed latency. It replaces the fixed-mode combinational adder/subtractor wherever a registered datapath with per-cycle mode switching is needed.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits per pipeline slice; 1 ≤ CHUNK ≤ WIDTH.
- STAGES, WIDTH/CHUNK, derived localparam; pipeline depth.

- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_ce  input  1  clock enable; 0 freezes the entire pipeline.
- i_valid  input  1  operand pair valid this cycle.
- i_sub  input  1  mode: 0 = a+b, 1 = a−b; travels with its operands.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- o_valid  output  1  result valid.
- o_res  output  WIDTH  result, modulo 2^WIDTH.
- o_c  output  1  add: carry-out; sub: borrow (1 when unsigned a < b).
- o_ovf  output  1  signed two's-complement overflow.

## Operation
- Subtraction is a + ~b + 1. Stage-1 carry-in is i_sub. Carry-out of the top slice is cout.
- o_c = cout for add and ~cout for sub.
- Let b' = b for add and ~b for sub. Then o_ovf = (a[MSB] == b'[MSB]) && (res[MSB] != a[MSB]).
- Stage k (1..STAGES) computes bits [k·CHUNK−1 : (k−1)·CHUNK] from that slice of A and b' plus the carry registered by stage k−1.
- Higher slices of A/B are delayed in input skew registers so that each slice meets its carry. Lower result slices are delayed in output deskew registers so the full word appears together.
- i_sub and i_valid are piped alongside the data. Mode may change every cycle with no bubbles.
- Internal slice, skew and carry registers load on every edge with i_ce=1, regardless of i_valid.
- o_res, o_c and o_ovf update only when the final-stage valid bit is 1. Otherwise they hold the last valid result.
- o_valid equals the final-stage valid bit.
- When STAGES=1 the block is a single registered adder/subtractor with no skew or deskew registers.

## Timing
- Reset (i_rst_n low, asynchronous): all valid bits, carries, data registers and every output clear to 0. Outputs stay 0 until the first valid result emerges.
- Reset asserted mid-operation discards all in-flight operations. No partial result is ever output.
- Reset deassertion is synchronised externally. The first capture is the first rising edge with i_rst_n=1.
- Latency: an operand pair sampled at rising edge n with i_valid=1 and i_ce=1 appears on the outputs after edge n+STAGES−1, i.e. STAGES enabled edges. Disabled edges do not count.
- Throughput: one operation per enabled cycle.
- A cycle with i_valid=0 inserts a bubble. The bubble reaches the output as o_valid=0 with o_res/o_c/o_ovf held.
- i_ce=0 holds every register, including o_valid. An o_valid=1 present before the stall remains asserted for the whole stall. The pipeline has no backpressure; upstream must honour i_ce.
- i_valid and i_ce are both sampled on the same edge. With i_ce=0, the inputs are ignored.

## Test plan
Use WIDTH=8, CHUNK=4 (STAGES=2) unless stated.
- Reset, then add 0x7F+0x01 and add 0xFF+0x01 on consecutive cycles. First result 2 enabled cycles later: 0x80, c=0, ovf=1. Next cycle: 0x00, c=1, ovf=0.
- Subtract 0x00−0x01, then subtract 0x80−0x01 back-to-back. Results 0xFF, c=1, ovf=0, then 0x7F, c=0, ovf=1.
- Alternate i_sub every cycle on a=0x35, b=0x1C. Outputs alternate 0x51 (c=0) and 0x19 (c=0) with no bubbles. Also check cross-slice carry 0x0F+0x01 → 0x10.
- Issue valid, bubble, valid. Output shows o_valid 1,0,1, and o_res holds its value during the bubble. Next, drop i_ce for 3 cycles with one op in flight: all outputs frozen, and the result emerges after exactly 2 enabled edges in total.
- Assert i_rst_n low mid-stream with 2 ops in flight. All outputs go to 0 immediately (asynchronously), and neither op ever appears.
- Random regression at WIDTH=32 with CHUNK ∈ {1,8,32}. Every output is compared against a golden reference model (a±b, carry/borrow, overflow), shifted by STAGES enabled cycles.
